// File: rtl/clawd_decode_pkg.sv
// clawd_decode_pkg: shared decode-cluster sizing defaults and issue-sequencer state type.
package clawd_decode_pkg;
    localparam int DEF_CLUSTER_SIZE = 32;
    localparam int DEF_PC_WIDTH     = 32;
    localparam int DEF_INST_WIDTH   = 16;
    localparam int DEF_ISSUE_WIDTH  = 4;
    typedef enum logic {IDLE, DRAIN} seq_state_t;
endpackage

// File: rtl/issue_lane_select.sv
// issue_lane_select: picks up to ISSUE_WIDTH lowest set indices of a mask, lane 0 = lowest.
module issue_lane_select #(
    parameter int CLUSTER_SIZE = 32,
    parameter int ISSUE_WIDTH  = 4,
    localparam int IW = $clog2(CLUSTER_SIZE)
) (
    input  logic [CLUSTER_SIZE-1:0]   mask_i,
    output logic [ISSUE_WIDTH*IW-1:0] lane_idx_o,
    output logic [ISSUE_WIDTH-1:0]    lane_found_o
);
    logic [CLUSTER_SIZE-1:0] rem;
    always_comb begin
        rem = mask_i;
        lane_idx_o = '0;
        lane_found_o = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            lane_found_o[l] = |rem;
            for (int i = CLUSTER_SIZE - 1; i >= 0; i--)
                if (rem[i]) lane_idx_o[l*IW +: IW] = IW'(i);
            rem[lane_idx_o[l*IW +: IW]] = 1'b0;
        end
    end
endmodule

// File: rtl/cluster_issue_sequencer.sv
// cluster_issue_sequencer: holds one fetched cluster and drains it ISSUE_WIDTH slots per fire.
// Optional CLUSTER_ISSUE_STATS_EN adds issued_count / dropped_count outputs.
module cluster_issue_sequencer import clawd_decode_pkg::*; #(
    parameter int CLUSTER_SIZE = DEF_CLUSTER_SIZE,
    parameter int PC_WIDTH     = DEF_PC_WIDTH,
    parameter int INST_WIDTH   = DEF_INST_WIDTH,
    parameter int ISSUE_WIDTH  = DEF_ISSUE_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cluster_ready,
    input  logic [CLUSTER_SIZE-1:0]          cluster_valid,
    input  logic [CLUSTER_SIZE*PC_WIDTH-1:0] cluster_pc,
    input  logic [CLUSTER_SIZE*INST_WIDTH-1:0] cluster_inst,
    input  logic                             flush_pipeline,
    output logic                             seq_busy,
    output logic [ISSUE_WIDTH-1:0]           issue_valid,
    output logic [ISSUE_WIDTH*PC_WIDTH-1:0]  issue_pc,
    output logic [ISSUE_WIDTH*INST_WIDTH-1:0] issue_inst,
    input  logic                             issue_ready,
    output logic                             drop_error
`ifdef CLUSTER_ISSUE_STATS_EN
    ,
    output logic [31:0]                      issued_count,
    output logic [15:0]                      dropped_count
`endif
);
    localparam int IW = $clog2(CLUSTER_SIZE);
    seq_state_t state_q, state_d;
    logic [CLUSTER_SIZE-1:0] pend_q, pend_d, clr, pend_left;
    logic [CLUSTER_SIZE*PC_WIDTH-1:0] pc_q;
    logic [CLUSTER_SIZE*INST_WIDTH-1:0] inst_q;
    logic drop_q, drop_d;
    logic [ISSUE_WIDTH*IW-1:0] lane_idx;
    logic [ISSUE_WIDTH-1:0] lane_found;
    logic fire, final_fire, accept, drop_evt;

    issue_lane_select #(.CLUSTER_SIZE(CLUSTER_SIZE), .ISSUE_WIDTH(ISSUE_WIDTH)) u_sel (
        .mask_i(pend_q), .lane_idx_o(lane_idx), .lane_found_o(lane_found)
    );

    always_comb begin
        issue_valid = (state_q == DRAIN) ? lane_found : '0;
        issue_pc = '0;
        issue_inst = '0;
        clr = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            issue_pc[l*PC_WIDTH +: PC_WIDTH] = pc_q[lane_idx[l*IW +: IW]*PC_WIDTH +: PC_WIDTH];
            issue_inst[l*INST_WIDTH +: INST_WIDTH] = inst_q[lane_idx[l*IW +: IW]*INST_WIDTH +: INST_WIDTH];
            if (issue_valid[l]) clr[lane_idx[l*IW +: IW]] = 1'b1;
        end
    end

    // Flush outranks fire, so a flushed cycle never counts as the final fire.
    always_comb begin
        fire = issue_ready && |issue_valid && !flush_pipeline;
        pend_left = pend_q & ~clr;
        final_fire = fire && pend_left == '0;
        accept = cluster_ready && |cluster_valid && (state_q == IDLE || final_fire);
        drop_evt = cluster_ready && state_q == DRAIN && !final_fire;
        drop_d = drop_q | drop_evt;
        state_d = state_q;
        pend_d = pend_q;
        if (flush_pipeline) begin
            state_d = IDLE;
            pend_d = '0;
        end else if (accept) begin
            state_d = DRAIN;
            pend_d = cluster_valid;
        end else if (fire) begin
            state_d = final_fire ? IDLE : DRAIN;
            pend_d = pend_left;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q <= '0;
            drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk)
        if (accept && !flush_pipeline) begin
            pc_q <= cluster_pc;
            inst_q <= cluster_inst;
        end

    assign seq_busy = state_q == DRAIN;
    assign drop_error = drop_q;

`ifdef CLUSTER_ISSUE_STATS_EN
    logic [31:0] issued_q;
    logic [15:0] dropped_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            dropped_q <= '0;
        end else begin
            if (fire) issued_q <= issued_q + 32'($countones(issue_valid));
            if (drop_evt && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
        end
    end
    assign issued_count = issued_q;
    assign dropped_count = dropped_q;
`endif
endmodule

// File: tb/tb_cluster_issue_sequencer.sv
// tb_cluster_issue_sequencer: directed steps with a slot scoreboard for cluster_issue_sequencer.
module tb_cluster_issue_sequencer;
    localparam int CS = 32, PW = 32, IWD = 16, NW = 4;
    typedef struct packed { logic [PW-1:0] pc; logic [IWD-1:0] inst; } slot_t;

    logic clk = 0, rst = 1, cluster_ready = 0, flush_pipeline = 0, issue_ready = 0;
    logic [CS-1:0] cluster_valid = '0;
    logic [CS*PW-1:0] cluster_pc = '0;
    logic [CS*IWD-1:0] cluster_inst = '0;
    logic seq_busy, drop_error;
    logic [NW-1:0] issue_valid;
    logic [NW*PW-1:0] issue_pc;
    logic [NW*IWD-1:0] issue_inst;
`ifdef CLUSTER_ISSUE_STATS_EN
    logic [31:0] issued_count;
    logic [15:0] dropped_count;
`endif

    cluster_issue_sequencer dut (
        .clk(clk), .rst(rst), .cluster_ready(cluster_ready), .cluster_valid(cluster_valid),
        .cluster_pc(cluster_pc), .cluster_inst(cluster_inst), .flush_pipeline(flush_pipeline),
        .seq_busy(seq_busy), .issue_valid(issue_valid), .issue_pc(issue_pc),
        .issue_inst(issue_inst), .issue_ready(issue_ready), .drop_error(drop_error)
`ifdef CLUSTER_ISSUE_STATS_EN
        , .issued_count(issued_count), .dropped_count(dropped_count)
`endif
    );

    always #5 clk = ~clk;

    slot_t q[$];
    int tests = 0, fails = 0;
    logic exp_drop = 0;
    int exp_issued = 0, exp_dropped = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t mk(input int seed, input int i);
        mk.pc = PW'(seed * 32'h0001_0000 + i * 4);
        mk.inst = IWD'((seed << 8) ^ (i * 3 + 1));
    endfunction

    task automatic load(input logic [CS-1:0] mask, input int seed);
        slot_t s;
        cluster_ready = 1;
        cluster_valid = mask;
        for (int i = 0; i < CS; i++) begin
            s = mk(seed, i);
            cluster_pc[i*PW +: PW] = s.pc;
            cluster_inst[i*IWD +: IWD] = s.inst;
        end
    endtask

    // One clock: check outputs at negedge against the scoreboard, then update the model.
    task automatic step(input logic rdy, input logic push);
        int n, sz;
        logic fin, evt;
        slot_t e;
        issue_ready = rdy;
        @(negedge clk);
        sz = q.size();
        n = sz > NW ? NW : sz;
        chk("issue_valid", 64'(issue_valid), 64'((1 << n) - 1));
        chk("seq_busy", 64'(seq_busy), 64'(sz != 0));
        chk("drop_error", 64'(drop_error), 64'(exp_drop));
`ifdef CLUSTER_ISSUE_STATS_EN
        chk("issued_count", 64'(issued_count), 64'(exp_issued));
        chk("dropped_count", 64'(dropped_count), 64'(exp_dropped));
`endif
        for (int l = 0; l < n; l++) begin
            e = q[l];
            chk($sformatf("pc_lane%0d", l), 64'(issue_pc[l*PW +: PW]), 64'(e.pc));
            chk($sformatf("inst_lane%0d", l), 64'(issue_inst[l*IWD +: IWD]), 64'(e.inst));
        end
        fin = rdy && n > 0 && !flush_pipeline && sz <= NW;
        evt = cluster_ready && sz != 0 && !fin;
        if (rdy && n > 0 && !flush_pipeline) begin
            for (int l = 0; l < n; l++) void'(q.pop_front());
            exp_issued += n;
        end
        if (flush_pipeline) q.delete();
        if (push && (sz == 0 || fin) && !flush_pipeline)
            for (int i = 0; i < CS; i++) if (cluster_valid[i]) q.push_back(mk(cluster_pc[i*PW+16 +: 16], i));
        if (evt) begin
            exp_drop = 1;
            if (exp_dropped != 16'hFFFF) exp_dropped++;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            exp_drop = 0;
            exp_issued = 0;
            exp_dropped = 0;
        end
        cluster_ready = 0;
        flush_pipeline = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(0, 0);
        rst = 0;
        step(0, 0);
        load(32'h0, 1);
        step(1, 1);
        step(1, 0);
        load(32'hFFFF_FFFF, 2);
        step(0, 1);
        for (int k = 0; k < 8; k++) step(1, 0);
        step(1, 0);
        load(32'h8000_0005, 3);
        step(0, 1);
        step(1, 0);
        step(1, 0);
        load(32'h0000_000F, 4);
        step(0, 1);
        for (int k = 0; k < 5; k++) step(0, 0);
        step(1, 0);
        step(1, 0);
        load(32'h0000_00FF, 5);
        step(0, 1);
        step(1, 0);
        load(32'h0000_0003, 6);
        step(1, 1);
        step(1, 0);
        step(1, 0);
        load(32'h0000_00FF, 7);
        step(0, 1);
        load(32'h0000_0F0F, 8);
        step(0, 0);
        step(1, 0);
        step(1, 0);
        step(1, 0);
        load(32'h0000_FFFF, 9);
        step(0, 1);
        step(1, 0);
        load(32'h0000_000F, 10);
        flush_pipeline = 1;
        step(1, 1);
        step(1, 0);
        load(32'h0000_00FF, 11);
        step(0, 1);
        step(1, 0);
        rst = 1;
        step(0, 0);
        rst = 0;
        step(1, 0);
        load(32'h0000_0030, 12);
        step(0, 1);
        step(1, 0);
        step(1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
